mux_scan_sequencer: RTL
=======================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1, giving settle cycles per channel before sampling; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  scan request; sampled only in IDLE.
REQ-005 SHALL have port sel  output  3  channel select to the downstream 8:1 mux ({k,j,i}).
REQ-006 SHALL have port en_n  output  1  mux enable, active low (drives l).
REQ-007 SHALL have port mux_in  input  1  selected mux data (m).
REQ-008 SHALL have port mux_in_n  input  1  complementary mux data (n).
REQ-009 SHALL have port word  output  8  assembled scan result; bit c = channel c.
REQ-010 SHALL have port valid  output  1  word available.
REQ-011 SHALL have port ready  input  1  consumer accepts word.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port err  output  1  sticky complement-check failure for the current/last scan.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE, HOLD.
REQ-015 IDLE: en_n=1, sel=0; start=1 at an edge -> SETTLE, channel counter ch=0, settle counter cleared, err cleared.
REQ-016 SETTLE: en_n=0, sel=ch; after exactly SETTLE_CYC cycles in SETTLE -> SAMPLE.
REQ-017 SAMPLE (one cycle): en_n=0, sel=ch; capture mux_in into internal shadow bit ch at the closing edge.
REQ-018 SAMPLE: if mux_in == mux_in_n at the sampling edge, err SHALL set and remain set until the next accepted start or reset.
REQ-019 SAMPLE with ch<7 -> SETTLE with ch+1; ch==7 -> HOLD, word loaded from shadow (with bit 7 = mux_in), valid=1.
REQ-020 Each channel SHALL take SETTLE_CYC+1 cycles; valid SHALL rise at edge E0+8*(SETTLE_CYC+1), E0 = edge accepting start.
REQ-021 word SHALL change only when loaded at entry to HOLD; it SHALL hold its value through IDLE and the following scan.
REQ-022 HOLD: en_n=1, sel=7 held; valid stays 1 until an edge with ready=1, then -> IDLE with valid=0.
REQ-023 start SHALL be ignored in SETTLE, SAMPLE, HOLD, including start coincident with the valid&ready edge; a new scan needs start in IDLE.
REQ-024 ready while valid=0 SHALL have no effect.
REQ-025 ch SHALL never exceed 7; no wrap-around occurs within a scan.

Reset
REQ-026 rst_n=0 SHALL immediately, without clk, force IDLE, ch=0, sel=0, en_n=1, word=0, valid=0, busy=0, err=0.
REQ-027 Reset asserted mid-scan SHALL abort the scan; partial shadow data SHALL never reach word.
REQ-028 After rst_n deasserts, the first edge SHALL behave as an IDLE edge.

Verification
REQ-029 SETTLE_CYC=1, mux pattern 0xA5 (mux_in_n=~mux_in), start pulse, ready=1 -> valid at E0+16, word=0xA5, err=0, busy falls the edge after.
REQ-030 SETTLE_CYC=3, pattern 0x3C, ready=0 for 10 cycles after valid -> valid, word=0x3C held stable; IDLE one edge after ready rises.
REQ-031 Channel 4 forced mux_in=mux_in_n=1 -> err=1 at end of ch4 SAMPLE, stays 1 through HOLD/IDLE; cleared by the next start.
REQ-032 rst_n pulsed low during ch 5 SETTLE -> outputs at reset values asynchronously; word remains 0; next scan is correct.
REQ-033 start held high continuously, ready=1 -> back-to-back scans with exactly one IDLE cycle between valid&ready edge and next SETTLE.
REQ-034 Check sel sequence 0..7 each held SETTLE_CYC+1 cycles with en_n=0, en_n=1 in IDLE/HOLD.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps an external 8:1 mux through channels 0..7, settles and samples each,
// checks the complementary data line, and hands the assembled byte out over valid/ready.
module mux_scan_sequencer #(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] sel,
    output logic       en_n,
    input  logic       mux_in,
    input  logic       mux_in_n,
    output logic [7:0] word,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;
    state_t     r_state, w_next;
    logic [2:0] r_ch;
    logic [3:0] r_cnt;
    logic [7:0] r_shadow, r_word;
    logic       r_err;
    logic       w_settled, w_last;
    assign w_settled = r_cnt == 4'(SETTLE_CYC - 1);
    assign w_last    = r_ch == 3'd7;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? SETTLE : IDLE;
            SETTLE:  w_next = w_settled ? SAMPLE : SETTLE;
            SAMPLE:  w_next = w_last ? HOLD : SETTLE;
            HOLD:    w_next = ready ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // word is only ever written from a completed scan, so an aborted scan never leaks shadow bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch     <= 3'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 8'd0;
            r_word   <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_ch  <= 3'd0;
                    r_cnt <= 4'd0;
                    r_err <= 1'b0;
                end
                SETTLE: r_cnt <= w_settled ? 4'd0 : r_cnt + 4'd1;
                SAMPLE: begin
                    r_shadow[r_ch] <= mux_in;
                    if (mux_in == mux_in_n) r_err <= 1'b1;
                    if (w_last) r_word <= {mux_in, r_shadow[6:0]};
                    else        r_ch   <= r_ch + 3'd1;
                end
                default: ;
            endcase
        end
    end
    assign sel   = (r_state == IDLE) ? 3'd0 : (r_state == HOLD) ? 3'd7 : r_ch;
    assign en_n  = (r_state == IDLE) || (r_state == HOLD);
    assign valid = r_state == HOLD;
    assign busy  = r_state != IDLE;
    assign word  = r_word;
    assign err   = r_err;
endmodule
